async_sram_burst_ctrl: RTL and testbench

- Parametrised successor to the board's single-word asynchronous RAM controller.
- Runs bursts of 1..2^LEN_W sequential words on the async pseudo-SRAM bus, with byte-lane write masking, programmable read and write wait counts, and bus turnaround cycles.
- Sits between the ANN weight/activation engines and the board RAM pins. Keeps flash deselected and the RAM in async mode.

---
 rtl/sram_pkg.sv | 33 +++
 rtl/async_sram_burst_ctrl_if.sv | 38 +++
 rtl/sram_wait_timer.sv | 30 +++
 rtl/async_sram_burst_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_async_sram_burst_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the async pseudo-SRAM burst controller.
// Holds the FSM state encoding, the board pin tie-off levels and the
// per-board default wait counts, plus a helper that turns a wait length into a timer load value.
package sram_pkg;

    // Wait counts fit a 4-bit timer (legal 1..15 for strobes, 0..3 for turnaround).
    localparam int WAIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ACT   = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_TURN     = 3'd5
    } sramState_t;

    // RAM stays in asynchronous mode and flash stays deselected.
    localparam logic RAM_ADV_TIE  = 1'b0;
    localparam logic RAM_CLK_TIE  = 1'b0;
    localparam logic FLASH_CE_TIE = 1'b1;

    // Board defaults.
    localparam int DEF_RD_WAIT  = 4;
    localparam int DEF_WR_WAIT  = 4;
    localparam int DEF_TURN_CYC = 1;

    // The timer raises its zero flag after (load+1) cycles, so an N-cycle wait loads N-1.
    function automatic logic [WAIT_W-1:0] waitLoad(input int cycles);
        return (cycles > 0) ? WAIT_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/async_sram_burst_ctrl_if.sv
// Engine-side handshakes of the SRAM burst controller.
// Ports: command (cmd_*), write-data stream (wr_*), read-data pulses (rd_*), burst done.
// master = engine side, slave = controller side.
interface async_sram_burst_ctrl_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
);
    localparam int BE_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              done;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_len,
        output wr_valid, wr_data, wr_be,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len,
        input  wr_valid, wr_data, wr_be,
        output cmd_ready, wr_ready, rd_valid, rd_data, done
    );

endinterface

// File: rtl/sram_wait_timer.sv
// Loadable down-counter with a zero flag, shared by all strobe and turnaround waits.
// Latency: zero rises (loadVal+1) cycles after the load edge, counting the load cycle's successor as the first.
// Backpressure: none; load always wins over counting.
module sram_wait_timer
    import sram_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/async_sram_burst_ctrl.sv
// Burst controller for the board's async pseudo-SRAM: 1..2^LEN_W sequential words per command, byte-masked writes.
// Latency: first read word RD_WAIT+1 cycles after accept, then every RD_WAIT; writes cost 1+WR_WAIT+1 cycles per word.
// Backpressure: cmd_ready only in IDLE; a write stalls in setup (CE held low) until wr_valid.
// Ports: clk, rst_n (sync, active low); bus = engine handshakes (slave modport);
// MemAdr/MemDB/RamCE/MemOE/MemWE/RamBE_n = RAM pins; RamAdv/RamClk/FlashCE = tie-offs.
module async_sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 4,
    parameter int RD_WAIT  = DEF_RD_WAIT,
    parameter int WR_WAIT  = DEF_WR_WAIT,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    async_sram_burst_ctrl_if.slave bus,
    output logic [ADDR_W-1:0]     MemAdr,
    inout  wire  [DATA_W-1:0]     MemDB,
    output logic                  RamCE,
    output logic                  MemOE,
    output logic                  MemWE,
    output logic [DATA_W/8-1:0]   RamBE_n,
    output logic                  RamAdv,
    output logic                  RamClk,
    output logic                  FlashCE
);

    localparam logic [WAIT_W-1:0] RD_LOAD   = waitLoad(RD_WAIT);
    localparam logic [WAIT_W-1:0] WR_LOAD   = waitLoad(WR_WAIT);
    localparam logic [WAIT_W-1:0] TURN_LOAD = waitLoad(TURN_CYC);

    sramState_t        state;
    logic              cmdRdyReg;
    logic              busEn;
    logic              rdValidReg;
    logic              doneReg;
    logic [DATA_W-1:0] rdDataReg;
    logic [DATA_W-1:0] wrDataReg;
    logic [LEN_W-1:0]  lenCnt;

    logic              tmrLoad;
    logic [WAIT_W-1:0] tmrVal;
    logic              tmrZero;

    logic              accept;
    logic              lastWord;
    logic              rdFire;
    logic              finish;

    assign accept   = bus.cmd_valid && cmdRdyReg && (state == ST_IDLE);
    assign lastWord = (lenCnt == '0);
    assign rdFire   = (state == ST_RD_ACT) && tmrZero;
    assign finish   = lastWord && (rdFire || (state == ST_WR_HOLD));

    // One timer serves the read strobe, the write pulse and the turnaround;
    // it is reloaded on the same edge that enters (or re-enters) the timed state.
    always_comb begin
        tmrLoad = 1'b0;
        tmrVal  = RD_LOAD;
        if (finish) begin
            tmrLoad = (TURN_CYC != 0);
            tmrVal  = TURN_LOAD;
        end else if ((accept && !bus.cmd_we) || rdFire) begin
            tmrLoad = 1'b1;
            tmrVal  = RD_LOAD;
        end else if ((state == ST_WR_SETUP) && bus.wr_valid) begin
            tmrLoad = 1'b1;
            tmrVal  = WR_LOAD;
        end
    end

    sram_wait_timer #(.W(WAIT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmrLoad),
        .loadVal (tmrVal),
        .zero    (tmrZero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmdRdyReg  <= 1'b1;
            RamCE      <= 1'b1;
            MemOE      <= 1'b1;
            MemWE      <= 1'b1;
            RamBE_n    <= '1;
            busEn      <= 1'b0;
            rdValidReg <= 1'b0;
            rdDataReg  <= '0;
            doneReg    <= 1'b0;
            MemAdr     <= '0;
            lenCnt     <= '0;
            wrDataReg  <= '0;
        end else begin
            rdValidReg <= 1'b0;
            doneReg    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmdRdyReg <= 1'b0;
                        MemAdr    <= bus.cmd_addr;
                        lenCnt    <= bus.cmd_len;
                        RamCE     <= 1'b0;
                        if (bus.cmd_we) begin
                            state <= ST_WR_SETUP;
                        end else begin
                            state   <= ST_RD_ACT;
                            MemOE   <= 1'b0;
                            RamBE_n <= '0;
                        end
                    end
                end

                ST_RD_ACT: begin
                    // Strobes stay low across words; only the address steps.
                    if (tmrZero) begin
                        rdDataReg  <= MemDB;
                        rdValidReg <= 1'b1;
                        if (!lastWord) begin
                            MemAdr <= MemAdr + 1'b1;
                            lenCnt <= lenCnt - 1'b1;
                        end
                    end
                end

                ST_WR_SETUP: begin
                    if (bus.wr_valid) begin
                        wrDataReg <= bus.wr_data;
                        RamBE_n   <= ~bus.wr_be;
                        busEn     <= 1'b1;
                        MemWE     <= 1'b0;
                        state     <= ST_WR_PULSE;
                    end
                end

                ST_WR_PULSE: begin
                    if (tmrZero) begin
                        MemWE <= 1'b1;
                        state <= ST_WR_HOLD;
                    end
                end

                ST_WR_HOLD: begin
                    // Data and address were held through this cycle; release now.
                    busEn   <= 1'b0;
                    RamBE_n <= '1;
                    if (!lastWord) begin
                        MemAdr <= MemAdr + 1'b1;
                        lenCnt <= lenCnt - 1'b1;
                        state  <= ST_WR_SETUP;
                    end
                end

                ST_TURN: begin
                    if (tmrZero) begin
                        state     <= ST_IDLE;
                        cmdRdyReg <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cmdRdyReg <= 1'b1;
                end
            endcase

            // End of burst overrides the per-state next values above.
            if (finish) begin
                RamCE   <= 1'b1;
                MemOE   <= 1'b1;
                RamBE_n <= '1;
                doneReg <= 1'b1;
                if (TURN_CYC == 0) begin
                    state     <= ST_IDLE;
                    cmdRdyReg <= 1'b1;
                end else begin
                    state <= ST_TURN;
                end
            end
        end
    end

    // Gated with rst_n so the controller reads as busy throughout reset and
    // ready from the very first cycle after release.
    assign bus.cmd_ready = cmdRdyReg && rst_n;
    assign bus.wr_ready  = (state == ST_WR_SETUP) && bus.wr_valid;
    assign bus.rd_valid  = rdValidReg;
    assign bus.rd_data   = rdDataReg;
    assign bus.done      = doneReg;

    // busEn is only ever set in write states, where MemOE is high.
    assign MemDB = busEn ? wrDataReg : 'z;

    assign RamAdv  = RAM_ADV_TIE;
    assign RamClk  = RAM_CLK_TIE;
    assign FlashCE = FLASH_CE_TIE;

endmodule

// File: tb/tb_async_sram_burst_ctrl.sv
// Directed bench for async_sram_burst_ctrl with a behavioural async RAM on the pins.
module tb_async_sram_burst_ctrl;

    localparam int ADDR_W   = 23;
    localparam int DATA_W   = 16;
    localparam int LEN_W    = 4;
    localparam int RD_WAIT  = 4;
    localparam int WR_WAIT  = 4;
    localparam int TURN_CYC = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    async_sram_burst_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    logic [22:0] MemAdr;
    wire  [15:0] MemDB;
    logic        RamCE, MemOE, MemWE;
    logic [1:0]  RamBE_n;
    logic        RamAdv, RamClk, FlashCE;

    async_sram_burst_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN_CYC(TURN_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .MemAdr  (MemAdr),
        .MemDB   (MemDB),
        .RamCE   (RamCE),
        .MemOE   (MemOE),
        .MemWE   (MemWE),
        .RamBE_n (RamBE_n),
        .RamAdv  (RamAdv),
        .RamClk  (RamClk),
        .FlashCE (FlashCE)
    );

    // ---------------- RAM model ----------------
    logic [15:0] mem [logic [22:0]];
    logic [15:0] rdWord = 16'h0000;
    logic [15:0] wTmp;

    function automatic logic [15:0] memRead(input logic [22:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    // Released bus floats high, so a driven bus is distinguishable from an idle one.
    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
        pullup (MemDB[gi]);
    end

    assign MemDB = (RamCE === 1'b0 && MemOE === 1'b0) ? rdWord : 16'hzzzz;

    always @(negedge clk) begin
        rdWord = memRead(MemAdr);
        if (RamCE === 1'b0 && MemWE === 1'b0) begin
            wTmp = memRead(MemAdr);
            if (RamBE_n[0] === 1'b0) wTmp[7:0]  = MemDB[7:0];
            if (RamBE_n[1] === 1'b0) wTmp[15:8] = MemDB[15:8];
            mem[MemAdr] = wTmp;
        end
    end

    // ---------------- bookkeeping ----------------
    int nChk  = 0;
    int nPass = 0;
    int nFail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [22:0] addr, input logic [3:0] len);
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        #1;
        tick;
    endtask

    // Per-burst observations; cycle 1 is the cycle right after the accept edge.
    int          oeCnt, nRd, doneCnt, doneCyc, np, acceptCyc, badRdy, stallWe, stallCe;
    logic        rdyAtDone, rdyAfterDone;
    logic [22:0] oeAdr;
    logic [15:0] rdDat [16];
    int          rdCyc [16];
    logic [22:0] pulseAdr [4];
    int          pulseLen [4];
    logic [15:0] pulseDat [4];
    logic [1:0]  pulseBe [4];
    logic [15:0] wq [4];
    int          nWr;
    logic [1:0]  curBe;

    task automatic run_burst(input int stallCyc, input bit holdCmd);
        int curLen;
        bit inPulse;
        bit consumed;
        int wrIdx;
        curLen = 0; inPulse = 0; wrIdx = 0;
        oeCnt = 0; nRd = 0; doneCnt = 0; doneCyc = 0; np = 0; acceptCyc = 0;
        badRdy = 0; stallWe = 0; stallCe = 0; rdyAtDone = 1'b0; rdyAfterDone = 1'b0; oeAdr = '0;
        if (!holdCmd) bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            bus.wr_valid = (c > stallCyc) && (wrIdx < nWr);
            bus.wr_data  = wq[(wrIdx < nWr) ? wrIdx : 0];
            bus.wr_be    = curBe;
            #1;
            if (MemOE === 1'b0) begin
                if (oeCnt == 0) oeAdr = MemAdr;
                oeCnt++;
            end
            if (MemWE === 1'b0) begin
                if (!inPulse && np < 4) begin
                    pulseAdr[np] = MemAdr;
                    pulseBe[np]  = RamBE_n;
                    pulseDat[np] = MemDB;
                end
                inPulse = 1;
                curLen++;
            end else if (inPulse) begin
                if (np < 4) pulseLen[np] = curLen;
                np++;
                inPulse = 0;
                curLen  = 0;
            end
            if (bus.rd_valid === 1'b1) begin
                if (nRd < 16) begin
                    rdDat[nRd] = bus.rd_data;
                    rdCyc[nRd] = c;
                end
                nRd++;
            end
            if (bus.done === 1'b1) begin
                if (doneCnt == 0) begin
                    doneCyc   = c;
                    rdyAtDone = bus.cmd_ready;
                end
                doneCnt++;
            end
            if (doneCnt > 0 && c == doneCyc + 1) rdyAfterDone = bus.cmd_ready;
            if (bus.cmd_valid && bus.cmd_ready === 1'b1 && acceptCyc == 0) acceptCyc = c;
            if (c <= stallCyc) begin
                if (bus.wr_ready !== 1'b0) badRdy++;
                if (MemWE !== 1'b1) stallWe++;
                if (RamCE !== 1'b0) stallCe++;
            end
            if (doneCnt > 0 && c == doneCyc + 2) break;
            consumed = (bus.wr_ready === 1'b1);
            tick;
            if (consumed) wrIdx++;
        end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int found;
        int dn;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.wr_be     = '0;
        nWr   = 0;
        curBe = 2'b11;

        mem[23'h000010] = 16'hBEEF;
        mem[23'h000040] = 16'h1234;
        mem[23'h000041] = 16'h5678;
        for (int i = 0; i < 16; i++) mem[23'h20 + 23'(i)] = 16'h5000 + 16'(i);

        // ---- reset state ----
        tick;
        tick;
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_RamCE", RamCE, 1);
        check("rst_MemOE", MemOE, 1);
        check("rst_MemWE", MemWE, 1);
        check("rst_RamBE_n", RamBE_n, 2'b11);
        check("rst_MemDB_released", MemDB, 16'hFFFF);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_MemAdr", MemAdr, 0);
        check("tie_FlashCE", FlashCE, 1);
        check("tie_RamAdv_RamClk", {RamAdv, RamClk}, 2'b00);
        rst_n = 1'b1;
        #1;
        check("rst_release_cmd_ready", bus.cmd_ready, 1);

        // ---- single read ----
        issue(1'b0, 23'h000010, 4'd0);
        run_burst(0, 1'b0);
        check("rd1_oe_cycles", oeCnt, RD_WAIT);
        check("rd1_addr", oeAdr, 23'h000010);
        check("rd1_count", nRd, 1);
        check("rd1_latency", rdCyc[0], RD_WAIT + 1);
        check("rd1_data", rdDat[0], 16'hBEEF);
        check("rd1_done_count", doneCnt, 1);
        check("rd1_done_cycle", doneCyc, RD_WAIT + 1);
        check("rd1_ready_in_turn", rdyAtDone, 0);
        check("rd1_ready_after", rdyAfterDone, 1);

        // ---- write burst of 3 with address wrap ----
        wq[0] = 16'h1111; wq[1] = 16'h2222; wq[2] = 16'h3333; nWr = 3; curBe = 2'b11;
        issue(1'b1, 23'h7FFFFE, 4'd2);
        run_burst(0, 1'b0);
        check("wr3_pulses", np, 3);
        check("wr3_adr0", pulseAdr[0], 23'h7FFFFE);
        check("wr3_adr1", pulseAdr[1], 23'h7FFFFF);
        check("wr3_adr2_wrap", pulseAdr[2], 23'h000000);
        bad = 0;
        for (int i = 0; i < 3; i++) if (pulseLen[i] != WR_WAIT || pulseDat[i] !== wq[i]) bad++;
        check("wr3_pulse_len_data", bad, 0);
        check("wr3_mem0", memRead(23'h7FFFFE), 16'h1111);
        check("wr3_mem1", memRead(23'h7FFFFF), 16'h2222);
        check("wr3_mem2", memRead(23'h000000), 16'h3333);
        check("wr3_done_cycle", doneCyc, 3 * (WR_WAIT + 2) + 1);
        check("wr3_oe_never_low", oeCnt, 0);

        // ---- byte-masked write, then read back ----
        wq[0] = 16'hABCD; nWr = 1; curBe = 2'b01;
        issue(1'b1, 23'h000040, 4'd0);
        run_burst(0, 1'b0);
        check("bm_be_n", pulseBe[0], 2'b10);
        check("bm_mem", memRead(23'h000040), 16'h12CD);
        nWr = 0;
        issue(1'b0, 23'h000040, 4'd0);
        run_burst(0, 1'b0);
        check("bm_readback", rdDat[0], 16'h12CD);

        // ---- all-lanes-masked write ----
        wq[0] = 16'hFFFF; nWr = 1; curBe = 2'b00;
        issue(1'b1, 23'h000041, 4'd0);
        run_burst(0, 1'b0);
        check("be0_pulses", np, 1);
        check("be0_be_n", pulseBe[0], 2'b11);
        check("be0_mem_untouched", memRead(23'h000041), 16'h5678);

        // ---- write stall ----
        wq[0] = 16'h9999; nWr = 1; curBe = 2'b11;
        issue(1'b1, 23'h000050, 4'd0);
        run_burst(7, 1'b0);
        check("stall_wr_ready", badRdy, 0);
        check("stall_we_high", stallWe, 0);
        check("stall_ce_low", stallCe, 0);
        check("stall_pulses", np, 1);
        check("stall_done_cycle", doneCyc, 7 + WR_WAIT + 2 + 1);
        check("stall_mem", memRead(23'h000050), 16'h9999);

        // ---- 16-word read burst, cmd_valid held ----
        nWr = 0;
        issue(1'b0, 23'h000020, 4'd15);
        run_burst(0, 1'b1);
        bus.cmd_valid = 1'b0;
        check("rb16_count", nRd, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rdCyc[i] != RD_WAIT * i + RD_WAIT + 1) bad++;
        check("rb16_spacing", bad, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rdDat[i] !== 16'h5000 + 16'(i)) bad++;
        check("rb16_data", bad, 0);
        check("rb16_done_cycle", doneCyc, 16 * RD_WAIT + 1);
        check("rb16_ready_in_turn", rdyAtDone, 0);
        check("rb16_second_accept", acceptCyc, 16 * RD_WAIT + 1 + TURN_CYC);
        found = 0;
        for (int c = 0; c < 100; c++) begin
            tick;
            if (bus.done === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("rb16_second_done", found, 1);
        tick;
        tick;

        // ---- reset during write pulse ----
        issue(1'b1, 23'h000060, 4'd1);
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 16'h1357;
        bus.wr_be     = 2'b11;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (MemWE === 1'b0) begin
                found = 1;
                break;
            end
        end
        bus.wr_valid = 1'b0;
        check("mr_pulse_seen", found, 1);
        tick;
        check("mr_bus_driven", MemDB, 16'h1357);
        rst_n = 1'b0;
        tick;
        check("mr_MemWE", MemWE, 1);
        check("mr_RamCE", RamCE, 1);
        check("mr_MemDB_released", MemDB, 16'hFFFF);
        check("mr_no_done", bus.done, 0);
        check("mr_cmd_ready_low", bus.cmd_ready, 0);
        rst_n = 1'b1;
        #1;
        check("mr_cmd_ready_after", bus.cmd_ready, 1);
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (bus.done !== 1'b0) dn++;
        end
        check("mr_done_quiet", dn, 0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
